// File: rtl/dcache_wt_pkg.sv
// Shared definitions for the write-through data cache: FSM encodings and default geometry.
package dcache_wt_pkg;

  localparam int DC_XLEN       = 32;
  localparam int DC_LINES      = 16;
  localparam int DC_LINE_WORDS = 4;

  typedef logic [1:0] dc_state_t;

  localparam dc_state_t DC_IDLE  = 2'd0;
  localparam dc_state_t DC_FILL  = 2'd1;
  localparam dc_state_t DC_WRITE = 2'd2;
  localparam dc_state_t DC_DONE  = 2'd3;

endpackage

// File: rtl/dcache_wt_if.sv
// Request/acknowledge bus between the data cache (master) and the slow data memory (slave).
interface dcache_wt_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_array.sv
// Tag, valid and data storage for the direct-mapped cache; async read, sync write,
// valid bits cleared asynchronously by rst_n (tags and data are never reset).
module dcache_array
  import dcache_wt_pkg::*;
#(
  parameter int LINES      = DC_LINES,
  parameter int LINE_WORDS = DC_LINE_WORDS,
  parameter int TAG_W      = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(LINES)-1:0]      idx,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
  output logic [TAG_W-1:0]              rd_tag,
  output logic                          rd_valid,
  output logic [DC_XLEN-1:0]            rd_data,
  input  logic                          word_we,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
  input  logic [DC_XLEN-1:0]            wr_data,
  input  logic                          tag_we,
  input  logic [TAG_W-1:0]              wr_tag,
  input  logic                          valid_clr
);

  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [DC_XLEN-1:0] data_mem [LINES*LINE_WORDS];
  logic [LINES-1:0]   valid_q;

  assign rd_tag   = tag_mem[idx];
  assign rd_valid = valid_q[idx];
  assign rd_data  = data_mem[{idx, rd_word}];

  // A miss invalidates the line before refilling so an abandoned fill never looks valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (valid_clr) begin
      valid_q[idx] <= 1'b0;
    end else if (tag_we) begin
      valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (word_we) begin
      data_mem[{idx, wr_word}] <= wr_data;
    end
    if (tag_we) begin
      tag_mem[idx] <= wr_tag;
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_wt
  import dcache_wt_pkg::*;
#(
  parameter int LINES      = DC_LINES,
  parameter int LINE_WORDS = DC_LINE_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_ren,
  input  logic               cpu_wen,
  input  logic [DC_XLEN-1:0] cpu_addr,
  input  logic [DC_XLEN-1:0] cpu_din,
  output logic [DC_XLEN-1:0] cpu_dout,
  output logic               cpu_stall,
  dcache_wt_if.master        mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  localparam int W     = $clog2(LINE_WORDS);
  localparam int I     = $clog2(LINES);
  localparam int TAG_W = DC_XLEN - W - I - 2;
  localparam logic [W-1:0] LAST_WORD = W'(LINE_WORDS - 1);

  logic [W-1:0]     word_sel;
  logic [I-1:0]     idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       unused_addr_bits;

  assign word_sel         = cpu_addr[W+1:2];
  assign idx              = cpu_addr[W+I+1:W+2];
  assign tag              = cpu_addr[DC_XLEN-1:W+I+2];
  assign unused_addr_bits = cpu_addr[1:0];

  dc_state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;

  logic [TAG_W-1:0]   rd_tag;
  logic               rd_valid;
  logic [DC_XLEN-1:0] rd_data;
  logic               hit;
  logic               word_we;
  logic [W-1:0]       wr_word;
  logic [DC_XLEN-1:0] wr_data;
  logic               fill_done;
  logic               valid_clr;

  logic               stall_c;
  logic [DC_XLEN-1:0] dout_c;
  logic               req_c;
  logic               we_c;
  logic [DC_XLEN-1:0] addr_c;
  logic [DC_XLEN-1:0] wdata_c;

  assign hit = rd_valid & (rd_tag == tag);

  dcache_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (idx),
    .rd_word   (word_sel),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .word_we   (word_we),
    .wr_word   (wr_word),
    .wr_data   (wr_data),
    .tag_we    (fill_done),
    .wr_tag    (tag),
    .valid_clr (valid_clr)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    dout_c    = '0;
    req_c     = 1'b0;
    we_c      = 1'b0;
    addr_c    = '0;
    wdata_c   = '0;
    word_we   = 1'b0;
    wr_word   = word_sel;
    wr_data   = cpu_din;
    fill_done = 1'b0;
    valid_clr = 1'b0;
    case (state_q)
      DC_IDLE: begin
        if (cpu_wen) begin
          stall_c = 1'b1;
          state_d = DC_WRITE;
        end else if (cpu_ren) begin
          if (hit) begin
            dout_c = rd_data;
          end else begin
            stall_c   = 1'b1;
            valid_clr = 1'b1;
            cnt_d     = '0;
            state_d   = DC_FILL;
          end
        end
      end
      DC_FILL: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        addr_c  = {tag, idx, cnt_q, 2'b00};
        if (mem.mem_ack) begin
          word_we = 1'b1;
          wr_word = cnt_q;
          wr_data = mem.mem_rdata;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            fill_done = 1'b1;
            state_d   = DC_IDLE;
          end
        end
      end
      DC_WRITE: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        we_c    = 1'b1;
        addr_c  = {cpu_addr[DC_XLEN-1:2], 2'b00};
        wdata_c = cpu_din;
        // Write-through updates the cached copy only on a hit; misses never allocate.
        if (mem.mem_ack) begin
          word_we = hit;
          state_d = DC_DONE;
        end
      end
      DC_DONE: begin
        state_d = DC_IDLE;
      end
      default: begin
        state_d = DC_IDLE;
      end
    endcase
  end

  // Reset forces the CPU-facing outputs quiet even while a held load would otherwise miss.
  assign cpu_stall     = stall_c & rst_n;
  assign cpu_dout      = rst_n ? dout_c : '0;
  assign mem.mem_req   = req_c;
  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = wdata_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        refill_q;
  logic [31:0] hit_q, hit_d;
  logic [31:0] miss_q, miss_d;

  // The lookup right after a fill completes the missed access, so it is not a fresh hit.
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (state_q == DC_IDLE && cpu_ren && !cpu_wen) begin
      if (!hit) begin
        miss_d = miss_q + 32'd1;
      end else if (!refill_q) begin
        hit_d = hit_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refill_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      refill_q <= fill_done;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Scoreboard bench for dcache_wt: directed scenarios followed by random loads/stores,
// checked against a line-level cache model and a flat memory model.
module tb_dcache_wt;
  import dcache_wt_pkg::*;

  localparam int LINES = 16;
  localparam int LW    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_ren, cpu_wen;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic        cpu_stall;

  always #5 clk = ~clk;

  dcache_wt_if mem_bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_wt #(.LINES(LINES), .LINE_WORDS(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_ren   (cpu_ren),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_stall (cpu_stall),
    .mem       (mem_bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  typedef struct {
    bit          is_store;
    logic [31:0] data;
    int          n_reads;
    int          stall;
  } op_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tr_t;

  op_t op_q[$];
  tr_t tr_q[$];

  int vectors = 0;
  int miscompares = 0;
  int ack_delay = 0;
  int done_cnt = 0;

  bit          ref_valid [LINES];
  int unsigned ref_tag   [LINES];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];
`ifdef DCACHE_STATS_EN
  int exp_hits = 0;
  int exp_misses = 0;
`endif

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  // Memory model: acknowledges each request after ack_delay waiting cycles.
  initial begin
    int waited;
    waited = 0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_bus.mem_ack) waited = 0;
      mem_bus.mem_ack = 1'b0;
      if (mem_bus.mem_req && rst_n) begin
        if (waited >= ack_delay) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = bus_rd(mem_bus.mem_addr);
          if (mem_bus.mem_we) bus_mem[mem_bus.mem_addr] = mem_bus.mem_wdata;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
    end
  end

  // Monitor: pops expected bus transfers and completed CPU accesses.
  initial begin
    int stall_run, reads_run;
    tr_t t;
    op_t o;
    stall_run = 0;
    reads_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_run = 0;
        reads_run = 0;
      end else begin
        if (mem_bus.mem_req && mem_bus.mem_ack) begin
          if (tr_q.size() == 0) begin
            check("mem_unexpected_xfer", mem_bus.mem_addr, 32'hFFFF_FFFF);
          end else begin
            t = tr_q.pop_front();
            check("mem_addr", mem_bus.mem_addr, t.addr);
            check("mem_we", 32'(mem_bus.mem_we), 32'(t.we));
            if (t.we) check("mem_wdata", mem_bus.mem_wdata, t.wdata);
            if (!t.we) reads_run++;
          end
        end
        if (cpu_stall) begin
          stall_run++;
        end else if (cpu_ren || cpu_wen) begin
          if (op_q.size() == 0) begin
            check("cpu_unexpected_done", cpu_addr, 32'hFFFF_FFFF);
          end else begin
            o = op_q.pop_front();
            if (!o.is_store) check("load_data", cpu_dout, o.data);
            check(o.is_store ? "store_stall_cycles" : "load_stall_cycles", stall_run, o.stall);
            check("fill_reads", reads_run, o.n_reads);
          end
          stall_run = 0;
          reads_run = 0;
          done_cnt++;
        end else begin
          check("idle_dout", cpu_dout, 32'h0);
        end
      end
    end
  end

  // Computes the expected outcome from the cache rules, then drives one access to completion.
  task automatic do_op(input bit st, input logic [31:0] a, input logic [31:0] d, input int dly);
    op_t         o;
    tr_t         t;
    logic [31:0] wa;
    int unsigned line, tg;
    bit          hit;
    int          start, cyc;
    wa   = {a[31:2], 2'b00};
    line = (wa / (LW * 4)) % LINES;
    tg   = wa / (LW * 4 * LINES);
    hit  = ref_valid[line] && (ref_tag[line] == tg);
    o.is_store = st;
    if (st) begin
      t.we = 1'b1; t.addr = wa; t.wdata = d;
      tr_q.push_back(t);
      ref_mem[wa] = d;
      o.data = d; o.n_reads = 0; o.stall = 2 + dly;
    end else begin
      if (hit) begin
        o.n_reads = 0; o.stall = 0;
`ifdef DCACHE_STATS_EN
        exp_hits++;
`endif
      end else begin
        for (int k = 0; k < LW; k++) begin
          t.we = 1'b0; t.addr = (wa / (LW * 4)) * (LW * 4) + k * 4; t.wdata = '0;
          tr_q.push_back(t);
        end
        ref_valid[line] = 1'b1;
        ref_tag[line]   = tg;
        o.n_reads = LW; o.stall = 1 + LW * (dly + 1);
`ifdef DCACHE_STATS_EN
        exp_misses++;
`endif
      end
      o.data = ref_rd(wa);
    end
    op_q.push_back(o);
    ack_delay = dly;
    cpu_addr  = a;
    cpu_din   = st ? d : $urandom;
    cpu_wen   = st;
    cpu_ren   = st ? 1'($urandom_range(0, 1)) : 1'b1;
    start = done_cnt;
    cyc   = 0;
    while (done_cnt == start) begin
      @(posedge clk);
      cyc++;
      if (cyc > 200 && done_cnt == start) begin
        vectors++;
        miscompares++;
        $display("FAIL op_timeout: addr %h not completed after %0d cycles", a, cyc);
        summary();
        $finish;
      end
    end
    #1;
    cpu_ren = 1'b0;
    cpu_wen = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tr_t t;
    logic [31:0] ra;
    rst_n    = 1'b0;
    cpu_ren  = 1'b1;
    cpu_wen  = 1'b0;
    cpu_addr = 32'h100;
    cpu_din  = 32'h0;
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;

    // Outputs are quiet under reset even with a load held on the inputs.
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_bus.mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_bus.mem_we), 32'h0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'h0);
    check("rst_mem_wdata", mem_bus.mem_wdata, 32'h0);
    check("rst_cpu_dout", cpu_dout, 32'h0);
    check("rst_cpu_stall", 32'(cpu_stall), 32'h0);
    cpu_ren = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(1'b0, 32'h100, 32'h0, 0);
    do_op(1'b0, 32'h108, 32'h0, 0);
    do_op(1'b1, 32'h104, 32'hDEAD_BEEF, 3);
    idle_cycles(1);
    do_op(1'b0, 32'h104, 32'h0, 0);
    do_op(1'b1, 32'h2000, 32'h1234_5678, 1);
    do_op(1'b0, 32'h2000, 32'h0, 0);
    do_op(1'b0, 32'h100, 32'h0, 0);
    do_op(1'b0, 32'h200, 32'h0, 0);
    do_op(1'b0, 32'h100, 32'h0, 0);

    // Abandoned fill: evict 0x100, start its refill, and reset after two acks.
    do_op(1'b0, 32'h400, 32'h0, 0);
    for (int k = 0; k < LW; k++) begin
      t.we = 1'b0; t.addr = 32'h100 + 32'(k * 4); t.wdata = '0;
      tr_q.push_back(t);
    end
    ack_delay = 0;
    cpu_addr  = 32'h100;
    cpu_ren   = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midfill_rst_mem_req", 32'(mem_bus.mem_req), 32'h0);
    check("midfill_rst_stall", 32'(cpu_stall), 32'h0);
    check("midfill_acks_seen", 32'(LW - tr_q.size()), 32'h2);
    tr_q.delete();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
`ifdef DCACHE_STATS_EN
    exp_hits   = 0;
    exp_misses = 0;
`endif
    cpu_ren = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(1'b0, 32'h100, 32'h0, 0);
    do_op(1'b0, 32'h10C, 32'h0, 0);

    for (int n = 0; n < 300; n++) begin
      ra = 32'($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) ra = ra | 32'h2000;
      do_op(($urandom_range(0, 3) == 0), ra, $urandom, $urandom_range(0, 2));
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(2);
    check("ops_left", 32'(op_q.size()), 32'h0);
    check("xfers_left", 32'(tr_q.size()), 32'h0);
`ifdef DCACHE_STATS_EN
    check("hit_cnt", hit_cnt, 32'(exp_hits));
    check("miss_cnt", miss_cnt, 32'(exp_misses));
`endif
    summary();
    $finish;
  end

endmodule

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through, no-write-allocate data cache between the MEM stage of the 5-stage MIPS datapath and the slow data memory. It serves MEM-stage loads combinationally on a hit. It stalls the pipeline on load misses, while a line is refilled over a req/ack bus. It also stalls on every store until the memory accepts the write-through. The stall output feeds the pipeline controller, which deasserts the stage enables while it is high.

## Interface
Parameters:
- LINES, 16: number of cache lines; power of two, ≥2.
- LINE_WORDS, 4: 32-bit words per line; power of two, ≥2.

Ports:
- clk  in  1  main clock; all state updates on posedge.
- rst_n  in  1  **asynchronous, active-low reset**.
- cpu_ren  in  1  MEM-stage load request.
- cpu_wen  in  1  MEM-stage store request.
- cpu_addr  in  32  byte address; bits [1:0] are ignored.
- cpu_din  in  32  store data.
- cpu_dout  out  32  load data; valid when cpu_ren=1 and cpu_stall=0.
- cpu_stall  out  1  freezes the pipeline while high.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data; valid when mem_ack=1.
- mem_ack  in  1  memory accepts the current request this cycle.

## Operation
- Address split, with W = log2(LINE_WORDS) and I = log2(LINES):
  - word select = addr[W+1:2]
  - index = addr[W+I+1:W+2]
  - tag = addr[31:W+I+2]
- hit = valid[index] & (tag_array[index] == tag).
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE:
  - cpu_wen=1: cpu_stall=1 combinationally; go to WRITE. cpu_wen has priority over cpu_ren.
  - cpu_ren=1 and hit: cpu_dout = selected word; cpu_stall=0.
  - cpu_ren=1 and miss: cpu_stall=1 combinationally; clear valid[index]; load the fill counter with 0; go to FILL.
  - No request: cpu_stall=0; cpu_dout=0.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = {tag, index, cnt, 2'b00}.
  - On mem_ack: write mem_rdata into word cnt; cnt++.
  - On the ack with cnt = LINE_WORDS-1: write the tag, set valid, go to IDLE. The re-lookup in IDLE hits and releases the stall.
  - Words are filled in order 0..LINE_WORDS-1; there is no critical-word-first.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr = {cpu_addr[31:2], 2'b00}, mem_wdata = cpu_din.
  - On mem_ack: if hit, update the cached word with cpu_din (write-through); a miss does not allocate. Go to DONE.
- DONE: cpu_stall=0 for exactly one cycle, and no request is examined, so the held store is not re-issued. Then go to IDLE.
- cpu_stall = 1 in FILL and WRITE, and in IDLE on a miss or store.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable from assertion until the cycle mem_ack=1.
  - A transfer completes on the posedge where mem_req & mem_ack are both high.
  - The next fill request may be presented in the following cycle.
  - mem_ack while mem_req=0 is ignored.
- cpu_addr and cpu_din are held stable by the stalled pipeline; the cache does not latch them.

## Timing
- Reset (asynchronous, immediate): state=IDLE, all valid bits 0, fill counter 0.
- Output values under reset: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_dout=0, cpu_stall=0.
- Load hit: 0-cycle latency (combinational), no stall.
- Load miss: stall for 1 + Σ(fill transfer cycles). With single-cycle ack, that is LINE_WORDS+1 stalled cycles; data is available in the following IDLE cycle.
- Store: stall for 1 + (cycles until ack), then DONE releases the stall for 1 cycle.
- Reset asserted mid-FILL: the partially filled line stays invalid and mem_req drops immediately. The memory must tolerate an abandoned request.
- Fill counter wraps to 0 after the last word.
- Tag and data arrays are not reset; only the valid bits are.

## Configuration
- DCACHE_STATS_EN defined:
  - Adds output ports hit_cnt[31:0] and miss_cnt[31:0].
  - Each counts load lookups in IDLE that start a fresh access. The post-fill re-lookup is not counted as a hit.
  - Both wrap modulo 2^32 and reset to 0.
- DCACHE_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared define header (alongside the existing MIPS defines) holds:
  - FSM state encodings: DC_IDLE=0, DC_FILL=1, DC_WRITE=2, DC_DONE=3.
  - Default LINES and LINE_WORDS.
- Sub-module dcache_array: tag, valid and data storage.
  - Async read by index and word.
  - Synchronous write of a word, and of tag+valid.
  - Async clear of valid on rst_n.
- The FSM, address split and handshake live in dcache_wt.

## Test plan
- Cold load from 0x100 with 1-cycle ack:
  - Stall is high for 5 cycles; mem_addr steps 0x100, 0x104, 0x108, 0x10C.
  - Then cpu_dout = mem[0x100] with stall low.
- Hit: reload 0x108 right after that fill -> cpu_dout = mem[0x108] the same cycle, no mem_req.
- Store 0xDEADBEEF to cached 0x104 with ack delayed 3 cycles:
  - mem_req/mem_addr/mem_wdata are held for 4 cycles, then one DONE cycle with stall low.
  - A later load of 0x104 hits and returns 0xDEADBEEF.
- Store to uncached 0x2000 -> write issued; a later load of 0x2000 misses (no allocate).
- Conflict: load 0x100, then 0x200 (same index, LINES=16, LINE_WORDS=4) -> second load misses and refills; reload of 0x100 misses again.
- rst_n pulled low in FILL after 2 acks:
  - mem_req drops the same cycle and cpu_stall goes to 0.
  - A reload of 0x100 misses and performs a full 4-word fill.
